des_key_schedule: RTL and testbench
===================================

// Module: des_key_schedule
// PURPOSE
//  Sequential DES key schedule feeding one 56-bit key (key1 or key2) into the triple-DES round engine.
//  Emits the 16 48-bit round subkeys one per accepted handshake. Order is K1..K16 for encrypt, K16..K1 for decrypt.
//  Sits directly upstream of the des round stage; the tripledes top instantiates one per DES pass.
// PARAMETERS
//  ROUNDS    16  number of subkeys per key; fixed at 16 for DES, other values unsupported
//  KEY_W     56  key width, post-PC-1 bit order
//  SUBKEY_W  48  subkey width, post-PC-2
// PORTS
//  clk         in   1   rising-edge clock
//  rst         in   1   asynchronous, active-high reset
//  start       in   1   begin a schedule; sampled only in IDLE
//  e           in   1   1 = encrypt order (K1 first), 0 = decrypt order (K16 first); latched with start
//  key         in   56  PC-1 key: C0 = key[55:28], D0 = key[27:0]; latched with start
//  ready       in   1   downstream accepts current subkey
//  subkey      out  48  PC-2(C,D) of current round
//  subkey_vld  out  1   subkey valid
//  round       out  4   index of current subkey, 0..15 = K1..K16 (counts down in decrypt)
//  busy        out  1   schedule in progress (RUN state)
//  done        out  1   one-cycle pulse after the 16th subkey is accepted
// BEHAVIOUR
//  Reset: state=IDLE; C,D,cnt=0; subkey=0, subkey_vld=0, round=0, busy=0, done=0.
//  FSM states: IDLE, LOAD, RUN, FIN.
//   IDLE: start=1 -> latch key/e, go LOAD. start while not IDLE is ignored; key/e changes are also ignored.
//   LOAD (1 cycle), encrypt: C,D <= rotl1(C0),rotl1(D0). Decrypt: C,D <= C0,D0, which equals C16,D16. cnt<=0 -> RUN.
//   RUN: subkey_vld=1, busy=1. subkey is combinational PC-2 of the C,D registers, so it is stable while vld & !ready.
//    On vld & ready with cnt<15: cnt++ and rotate C,D for the next round.
//     Shift amount per round n (1-based, n = next round): n in {1,2,9,16} -> 1, else 2.
//     Encrypt rotates left. Decrypt rotates right, using the amount of the round just issued (K(16-cnt)).
//    On vld & ready with cnt==15 -> FIN.
//   FIN: done=1 and subkey_vld=0 for one cycle, then IDLE. A start in FIN is ignored.
//  Latency: start to first subkey_vld = 2 cycles. With ready held high, 16 subkeys arrive in 16 consecutive cycles.
//  round = cnt for encrypt, 15-cnt for decrypt.
//  Rotation is modulo 28 on each half independently. C and D never mix except through PC-2.
//  ready while !subkey_vld has no effect.
//  Reset asserted mid-schedule: immediate return to reset values; no done pulse; the partial schedule is discarded.
//  Simultaneous ready on the final subkey and start: start is not sampled (state is RUN), so it must be re-issued in IDLE.
// CONFIGURATION
//  KS_ZEROIZE_EN defined: C and D are cleared to 0 on entry to FIN, and subkey is forced to 0 whenever subkey_vld=0.
//   No key material remains in flops after done.
//  KS_ZEROIZE_EN undefined: C and D keep their last rotation (C0,D0 after encrypt; C1,D1 after decrypt).
//   subkey then shows PC-2 of those registers while idle. No other behavioural difference.
// TESTING
//  1 Encrypt, key=56'hF0CCAAF556678F, ready=1: first subkey 48'h1B02EFFC7072 with round=0;
//    16th subkey 48'hCB3D8B0E17F5 with round=15; done pulses 1 cycle later.
//  2 Decrypt, same key: first subkey 48'hCB3D8B0E17F5 with round=15; last subkey 48'h1B02EFFC7072 with round=0.
//  3 Backpressure: ready=0 for 5 cycles at round 3: subkey and round stay constant, vld stays 1,
//    and round 4 follows the first ready cycle.
//  4 Reset mid-run (rst pulsed at round 7): all outputs 0 in the same cycle; a fresh start gives K1 again.
//  5 start pulsed in RUN with a different key: ignored, and the sequence still matches the original key.
//    A back-to-back start in the cycle after done begins a new schedule.
//  6 KS_ZEROIZE_EN build: after done, internal C/D are 0 and subkey=0.
//    Non-zeroize build: subkey idles at PC-2(C0,D0) after an encrypt run.

Source files
------------

// File: rtl/des_key_schedule.sv
// -----------------------------------------------------------------------------
// des_key_schedule
//   Sequential DES key schedule. Takes one 56-bit PC-1 key and emits the 16
//   48-bit round subkeys, one per accepted valid/ready handshake. The order is
//   K1..K16 when e=1 (encrypt) and K16..K1 when e=0 (decrypt).
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      begin a schedule (sampled only in IDLE)
//   e          1 = encrypt order, 0 = decrypt order (latched with start)
//   key[55:0]  PC-1 key, C0 = key[55:28], D0 = key[27:0] (latched with start)
//   ready      downstream accepts the current subkey
//   subkey     PC-2 of the current C,D registers
//   subkey_vld subkey valid (RUN state)
//   round      index of current subkey, 0..15 = K1..K16
//   busy       schedule in progress
//   done       one-cycle pulse after the 16th subkey is accepted
//
// Configuration macro
//   KS_ZEROIZE_EN : clear C/D on entry to FIN and force subkey to 0 whenever
//                   subkey_vld is low, so no key material lingers after done.
// -----------------------------------------------------------------------------
module des_key_schedule #(
  parameter int ROUNDS   = 16,
  parameter int KEY_W    = 56,
  parameter int SUBKEY_W = 48
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                e,
  input  logic [KEY_W-1:0]    key,
  input  logic                ready,
  output logic [SUBKEY_W-1:0] subkey,
  output logic                subkey_vld,
  output logic [3:0]          round,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_FIN} state_t;

  localparam logic [3:0] LAST_CNT = 4'(ROUNDS - 1);

  // PC-2 selection table in DES numbering (bit 1 = MSB of the 56-bit C||D).
  localparam logic [5:0] PC2_TAB [48] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  // Rotation amount for DES round n (1-based).
  function automatic logic [1:0] shift_amt(input logic [4:0] n);
    logic [1:0] amt;
    case (n)
      5'd1, 5'd2, 5'd9, 5'd16: amt = 2'd1;
      default:                 amt = 2'd2;
    endcase
    return amt;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] amt);
    return (amt == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] amt);
    return (amt == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic [27:0] r_c;
  logic [27:0] r_d;
  logic [3:0]  r_cnt;
  logic        r_e;

  logic [1:0]  w_amt;
  logic [27:0] w_c_step;
  logic [27:0] w_d_step;
  logic [55:0] w_cd;
  logic [47:0] w_pc2;
  logic        w_run;
  logic        w_accept;

  assign w_cd     = {r_c, r_d};
  assign w_run    = (r_state == S_RUN);
  assign w_accept = w_run & ready;

  // PC-2 compression: DES bit p of C||D lives at w_cd[56-p].
  for (genvar g = 0; g < 48; g++) begin : g_pc2
    assign w_pc2[47-g] = w_cd[56-PC2_TAB[g]];
  end

  // Per-handshake rotation: encrypt looks ahead to round cnt+2, decrypt
  // undoes the shift of the round just issued, K(16-cnt).
  always_comb begin
    w_amt    = 2'd1;
    w_c_step = r_c;
    w_d_step = r_d;
    if (r_e) begin
      w_amt    = shift_amt({1'b0, r_cnt} + 5'd2);
      w_c_step = rotl28(r_c, w_amt);
      w_d_step = rotl28(r_d, w_amt);
    end else begin
      w_amt    = shift_amt(5'd16 - {1'b0, r_cnt});
      w_c_step = rotr28(r_c, w_amt);
      w_d_step = rotr28(r_d, w_amt);
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_LOAD;
        else       w_state_nxt = S_IDLE;
      end
      S_LOAD: w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_accept && (r_cnt == LAST_CNT)) w_state_nxt = S_FIN;
        else                                 w_state_nxt = S_RUN;
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, key halves and round counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_c     <= 28'd0;
      r_d     <= 28'd0;
      r_cnt   <= 4'd0;
      r_e     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_c <= key[KEY_W-1:KEY_W/2];
            r_d <= key[KEY_W/2-1:0];
            r_e <= e;
          end
        end
        S_LOAD: begin
          // Decrypt starts from C0,D0 unchanged since C16,D16 == C0,D0.
          if (r_e) begin
            r_c <= rotl28(r_c, 2'd1);
            r_d <= rotl28(r_d, 2'd1);
          end
          r_cnt <= 4'd0;
        end
        S_RUN: begin
          if (w_accept) begin
            if (r_cnt != LAST_CNT) begin
              r_cnt <= r_cnt + 4'd1;
              r_c   <= w_c_step;
              r_d   <= w_d_step;
            end else begin
`ifdef KS_ZEROIZE_EN
              r_c <= 28'd0;
              r_d <= 28'd0;
`else
              r_c <= r_c;
              r_d <= r_d;
`endif
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode from the state register.
  always_comb begin
    subkey_vld = w_run;
    busy       = w_run;
    done       = (r_state == S_FIN);
    round      = 4'd0;
    if (w_run) begin
      round = r_e ? r_cnt : (LAST_CNT - r_cnt);
    end else begin
      round = 4'd0;
    end
`ifdef KS_ZEROIZE_EN
    subkey = w_run ? w_pc2 : 48'd0;
`else
    subkey = w_pc2;
`endif
  end

endmodule

// File: tb/tb_des_key_schedule.sv
module tb_des_key_schedule;

  logic        clk;
  logic        rst;
  logic        start;
  logic        e;
  logic [55:0] key;
  logic        ready;
  logic [47:0] subkey;
  logic        subkey_vld;
  logic [3:0]  round;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  des_key_schedule dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .e          (e),
    .key        (key),
    .ready      (ready),
    .subkey     (subkey),
    .subkey_vld (subkey_vld),
    .round      (round),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference DES PC-2 table, 1-based bit numbers of C||D.
  int pc2_t [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
                     16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
                     44,49,39,56,34,53, 46,42,50,36,29,32};

  // Reference subkey Kn: rotate C0/D0 left by the cumulative shift count.
  function automatic logic [47:0] ref_key(input logic [55:0] k, input int n);
    int          tot;
    logic [27:0] c;
    logic [27:0] d;
    logic [55:0] cd;
    logic [47:0] r;
    logic [5:0]  p;
    logic [5:0]  q;
    tot = 0;
    for (int j = 1; j <= n; j++) tot += (j == 1 || j == 2 || j == 9 || j == 16) ? 1 : 2;
    c = k[55:28];
    d = k[27:0];
    for (int j = 0; j < tot; j++) begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    cd = {c, d};
    r  = 48'd0;
    for (int i = 0; i < 48; i++) begin
      p = 6'(56 - pc2_t[i]);
      q = 6'(47 - i);
      r[q] = cd[p];
    end
    return r;
  endfunction

  typedef struct packed {
    logic [47:0] sk;
    logic [3:0]  rnd;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [55:0] key;
    logic        e;
    logic [47:0] first;
    logic [47:0] last;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_sched(input logic [55:0] k, input logic enc);
    exp_t x;
    for (int i = 1; i <= 16; i++) begin
      int n;
      n     = enc ? i : 17 - i;
      x.sk  = ref_key(k, n);
      x.rnd = 4'(n - 1);
      sbq.push_back(x);
    end
  endtask

  // Drive start for one cycle; leaves the DUT in LOAD.
  task automatic launch(input logic [55:0] k, input logic enc);
    key   = k;
    e     = enc;
    start = 1'b1;
    push_sched(k, enc);
    tick;
    start = 1'b0;
  endtask

  // Scoreboard: every accepted subkey must match the next expected one.
  always @(negedge clk) begin
    if (!rst && subkey_vld && ready) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_extra: got subkey %0h round %0d expected no handshake", subkey, round);
      end else begin
        exp_t x;
        x = sbq.pop_front();
        chk("sb_subkey", 64'(subkey), 64'(x.sk));
        chk("sb_round", 64'(round), 64'(x.rnd));
      end
    end
  end

  initial begin
    logic [47:0] idle_exp;
    logic [55:0] kat_key;
    logic [55:0] key_b;
    kat_key = 56'hF0CCAAF556678F;
    key_b   = 56'h0F1E2D3C4B5A69;

    vecs[0] = '{kat_key, 1'b1, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5};
    vecs[1] = '{kat_key, 1'b0, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072};
    vecs[2] = '{56'h00000000000000, 1'b1, 48'd0, 48'd0};
    vecs[3] = '{56'hFFFFFFFFFFFFFF, 1'b0, 48'd0, 48'd0};
    vecs[4] = '{56'h123456789ABCDE, 1'b1, 48'd0, 48'd0};
    vecs[5] = '{56'h80000010000001, 1'b0, 48'd0, 48'd0};
    for (int i = 2; i < 6; i++) begin
      vecs[i].first = ref_key(vecs[i].key, vecs[i].e ? 1 : 16);
      vecs[i].last  = ref_key(vecs[i].key, vecs[i].e ? 16 : 1);
    end

    rst = 1'b1; start = 1'b0; e = 1'b0; key = 56'd0; ready = 1'b0;
    #12;
    chk("rst_subkey", 64'(subkey), 64'd0);
    chk("rst_vld", 64'(subkey_vld), 64'd0);
    chk("rst_round", 64'(round), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    tick;
    rst = 1'b0;
    tick;

    // Full-rate schedules from the vector table.
    for (int v = 0; v < 6; v++) begin
      ready = 1'b1;
      launch(vecs[v].key, vecs[v].e);
      chk("load_vld", 64'(subkey_vld), 64'd0);
      tick;
      chk("first_vld", 64'(subkey_vld), 64'd1);
      chk("first_busy", 64'(busy), 64'd1);
      chk("first_subkey", 64'(subkey), 64'(vecs[v].first));
      chk("first_round", 64'(round), vecs[v].e ? 64'd0 : 64'd15);
      repeat (15) tick;
      chk("last_subkey", 64'(subkey), 64'(vecs[v].last));
      chk("last_round", 64'(round), vecs[v].e ? 64'd15 : 64'd0);
      tick;
      chk("fin_done", 64'(done), 64'd1);
      chk("fin_vld", 64'(subkey_vld), 64'd0);
      chk("fin_busy", 64'(busy), 64'd0);
      tick;
      chk("done_pulse", 64'(done), 64'd0);
      chk("sb_drained", 64'(sbq.size()), 64'd0);
`ifdef KS_ZEROIZE_EN
      idle_exp = 48'd0;
`else
      idle_exp = ref_key(vecs[v].key, vecs[v].e ? 16 : 1);
`endif
      chk("idle_subkey", 64'(subkey), 64'(idle_exp));
    end

    // Backpressure at round 3.
    ready = 1'b0;
    launch(kat_key, 1'b1);
    tick;
    ready = 1'b1;
    repeat (3) tick;
    chk("bp_round3", 64'(round), 64'd3);
    ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick;
      chk("bp_hold_round", 64'(round), 64'd3);
      chk("bp_hold_vld", 64'(subkey_vld), 64'd1);
      chk("bp_hold_subkey", 64'(subkey), 64'(ref_key(kat_key, 4)));
    end
    ready = 1'b1;
    tick;
    chk("bp_round4", 64'(round), 64'd4);
    repeat (12) tick;
    chk("bp_done", 64'(done), 64'd1);
    tick;
    chk("bp_drained", 64'(sbq.size()), 64'd0);

    // Reset in the middle of a schedule.
    launch(56'h123456789ABCDE, 1'b1);
    tick;
    repeat (7) tick;
    chk("mid_round7", 64'(round), 64'd7);
    rst = 1'b1;
    #1;
    chk("mid_rst_subkey", 64'(subkey), 64'd0);
    chk("mid_rst_vld", 64'(subkey_vld), 64'd0);
    chk("mid_rst_round", 64'(round), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    sbq.delete();
    tick;
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick;
      chk("post_rst_done", 64'(done), 64'd0);
      chk("post_rst_busy", 64'(busy), 64'd0);
    end
    launch(kat_key, 1'b1);
    tick;
    chk("restart_k1", 64'(subkey), 64'h1B02EFFC7072);
    chk("restart_round", 64'(round), 64'd0);
    repeat (16) tick;
    chk("restart_done", 64'(done), 64'd1);
    tick;
    chk("restart_drained", 64'(sbq.size()), 64'd0);

    // Start in RUN is ignored; back-to-back start after done is taken.
    launch(kat_key, 1'b1);
    tick;
    tick;
    key = key_b; e = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (13) tick;
    chk("ign_last_subkey", 64'(subkey), 64'hCB3D8B0E17F5);
    chk("ign_last_round", 64'(round), 64'd15);
    tick;
    chk("ign_done", 64'(done), 64'd1);
    tick;
    launch(key_b, 1'b0);
    tick;
    chk("b2b_vld", 64'(subkey_vld), 64'd1);
    chk("b2b_round", 64'(round), 64'd15);
    chk("b2b_subkey", 64'(subkey), 64'(ref_key(key_b, 16)));
    repeat (16) tick;
    chk("b2b_done", 64'(done), 64'd1);
    tick;
    chk("b2b_drained", 64'(sbq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
